ps2_key_tracker: RTL and testbench

PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

---
 rtl/ps2_key_tracker.sv | 201 ++++++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver: synchronised and glitch-filtered line sampling, frame FSM,
// E0/F0 prefix decoder, per-key held state and a first-word fall-through event FIFO.
module ps2_key_tracker #(
   parameter int                    NUM_KEYS    = 4,
   // entry 0 (bits [8:0]) is 9'h029, the space bar
   parameter logic [NUM_KEYS*9-1:0] KEY_CODES   = {9'h172, 9'h174, 9'h16B, 9'h029},
   parameter int                    FIFO_DEPTH  = 8,
   parameter int                    FILTER_LEN  = 8,
   parameter int                    TIMEOUT_CYC = 100000
) (
   input  logic                          CLOCK_50,
   input  logic                          reset,
   input  logic                          PS2_CLK,
   input  logic                          PS2_DAT,
   output logic [NUM_KEYS-1:0]           key_down,
   output logic                          ev_valid,
   input  logic                          ev_ready,
   output logic [7:0]                    ev_code,
   output logic                          ev_ext,
   output logic                          ev_break,
   output logic [$clog2(FIFO_DEPTH):0]   ev_count,
   output logic                          overflow,
   output logic                          frame_err
);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int FCNT_W = $clog2(FILTER_LEN + 1);
   localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;
   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       brk;
   } ev_t;

   logic              clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
   logic              filt_q, filt_d, filt_prev_q;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   rx_state_e         state_q, state_d;
   logic [7:0]        shift_q, shift_d, byte_q, byte_d;
   logic [2:0]        bitcnt_q, bitcnt_d;
   logic              par_q, par_d, byte_vld_q, byte_vld_d, ferr_q, ferr_d;
   logic [TO_W-1:0]   tcnt_q, tcnt_d;
   logic              ext_q, ext_d, brk_q, brk_d, evt_vld_q, evt_vld_d;
   ev_t               evt_q, evt_d;
   logic [NUM_KEYS-1:0] key_q, key_d;
   ev_t               fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              fall, push, pop, full, wr_en;

   // Clock filter: flip only after FILTER_LEN consecutive samples disagree with it
   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      if (clk_sync_q != filt_q) begin
         if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) filt_d = clk_sync_q;
         else                                    fcnt_d = fcnt_q + 1'b1;
      end
   end

   assign fall = filt_prev_q & ~filt_q;

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bitcnt_d   = bitcnt_q;
      par_d      = par_q;
      byte_d     = byte_q;
      byte_vld_d = 1'b0;
      ferr_d     = 1'b0;
      tcnt_d     = (state_q == IDLE || fall) ? '0 : tcnt_q + 1'b1;
      if (fall) begin
         case (state_q)
            IDLE: begin
               if (!dat_sync_q) begin
                  state_d  = DATA;
                  shift_d  = '0;
                  bitcnt_d = '0;
               end else begin
                  ferr_d = 1'b1;
               end
            end
            DATA: begin
               shift_d  = {dat_sync_q, shift_q[7:1]};
               bitcnt_d = bitcnt_q + 1'b1;
               if (bitcnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
               par_d   = ^{shift_q, dat_sync_q};
               state_d = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (dat_sync_q && par_q) begin
                  byte_vld_d = 1'b1;
                  byte_d     = shift_q;
               end else begin
                  ferr_d = 1'b1;
               end
            end
         endcase
      end else if (state_q != IDLE && tcnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
         state_d = IDLE;
         ferr_d  = 1'b1;
      end
   end

   // Prefix decoder: E0/F0 arm flags, housekeeping bytes vanish without touching them
   always_comb begin
      ext_d     = ext_q;
      brk_d     = brk_q;
      evt_vld_d = 1'b0;
      evt_d     = evt_q;
      if (byte_vld_q) begin
         case (byte_q)
            8'hE0: ext_d = 1'b1;
            8'hF0: brk_d = 1'b1;
            8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE: begin end
            default: begin
               evt_vld_d = 1'b1;
               evt_d     = '{code: byte_q, ext: ext_q, brk: brk_q};
               ext_d     = 1'b0;
               brk_d     = 1'b0;
            end
         endcase
      end
      if (ferr_q) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
      end
   end

   always_comb begin
      key_d = key_q;
      if (evt_vld_q)
         for (int i = 0; i < NUM_KEYS; i++)
            if ({evt_q.ext, evt_q.code} == KEY_CODES[i*9 +: 9]) key_d[i] = ~evt_q.brk;
   end

   assign ev_valid = (count_q != '0);
   assign full     = (count_q == CNT_W'(FIFO_DEPTH));
   assign push     = evt_vld_q;
   assign pop      = ev_valid & ev_ready;
   assign wr_en    = push & (~full | pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(wr_en) - CNT_W'(pop);
      ovf_d    = ovf_q | (push & full & ~pop);
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         clk_meta_q <= 1'b1;  clk_sync_q <= 1'b1;
         dat_meta_q <= 1'b1;  dat_sync_q <= 1'b1;
         filt_q     <= 1'b1;  filt_prev_q <= 1'b1;
         fcnt_q     <= '0;
         state_q    <= IDLE;
         shift_q    <= '0;    bitcnt_q <= '0;
         par_q      <= 1'b0;  tcnt_q   <= '0;
         byte_q     <= '0;    byte_vld_q <= 1'b0;
         ferr_q     <= 1'b0;
         ext_q      <= 1'b0;  brk_q    <= 1'b0;
         evt_vld_q  <= 1'b0;  evt_q    <= '0;
         key_q      <= '0;
         wr_ptr_q   <= '0;    rd_ptr_q <= '0;
         count_q    <= '0;    ovf_q    <= 1'b0;
      end else begin
         clk_meta_q <= PS2_CLK;  clk_sync_q <= clk_meta_q;
         dat_meta_q <= PS2_DAT;  dat_sync_q <= dat_meta_q;
         filt_q     <= filt_d;   filt_prev_q <= filt_q;
         fcnt_q     <= fcnt_d;
         state_q    <= state_d;
         shift_q    <= shift_d;  bitcnt_q <= bitcnt_d;
         par_q      <= par_d;    tcnt_q   <= tcnt_d;
         byte_q     <= byte_d;   byte_vld_q <= byte_vld_d;
         ferr_q     <= ferr_d;
         ext_q      <= ext_d;    brk_q    <= brk_d;
         evt_vld_q  <= evt_vld_d; evt_q   <= evt_d;
         key_q      <= key_d;
         wr_ptr_q   <= wr_ptr_d; rd_ptr_q <= rd_ptr_d;
         count_q    <= count_d;  ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (wr_en) fifo_mem[wr_ptr_q] <= evt_q;
   end

   assign key_down  = key_q;
   assign ev_code   = fifo_mem[rd_ptr_q].code;
   assign ev_ext    = fifo_mem[rd_ptr_q].ext;
   assign ev_break  = fifo_mem[rd_ptr_q].brk;
   assign ev_count  = count_q;
   assign overflow  = ovf_q;
   assign frame_err = ferr_q;
endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: a byte-level keyboard model predicts events,
// key state and frame errors; a negedge monitor pops and compares FIFO output.
module tb_ps2_key_tracker;
   localparam int NK = 4, FD = 8, FL = 8, TO = 1000, H = 20;
   localparam logic [NK*9-1:0] KC = {9'h172, 9'h174, 9'h16B, 9'h029};

   logic          clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_dat = 1'b1, ev_ready = 1'b0;
   logic [NK-1:0] key_down;
   logic          ev_valid, ev_ext, ev_break, overflow, frame_err;
   logic [7:0]    ev_code;
   logic [$clog2(FD):0] ev_count;

   always #5 clk = ~clk;

   ps2_key_tracker #(.NUM_KEYS(NK), .KEY_CODES(KC), .FIFO_DEPTH(FD),
                     .FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
      .CLOCK_50(clk), .reset(reset), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
      .key_down(key_down), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
      .ev_ext(ev_ext), .ev_break(ev_break), .ev_count(ev_count), .overflow(overflow),
      .frame_err(frame_err));

   int            checks = 0, passes = 0;
   int            ferr_seen = 0, ferr_exp = 0;
   logic [9:0]    exp_q[$];
   logic          m_ext = 1'b0, m_brk = 1'b0, m_ovf = 1'b0;
   logic [NK-1:0] mkey = '0;
   logic [NK*9-1:0] kc = KC;
   bit            rand_rdy = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Keyboard-level model: prefixes, discards, events, held keys and FIFO capacity
   task automatic model_byte(input logic [7:0] b, input bit pop_same);
      case (b)
         8'hE0: m_ext = 1'b1;
         8'hF0: m_brk = 1'b1;
         8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE: begin end
         default: begin
            if (exp_q.size() < FD || pop_same) exp_q.push_back({b, m_ext, m_brk});
            else m_ovf = 1'b1;
            for (int i = 0; i < NK; i++)
               if ({m_ext, b} == kc[i*9 +: 9]) mkey[i] = !m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
         end
      endcase
   endtask

   task automatic model_ferr();
      ferr_exp++;
      m_ext = 1'b0;
      m_brk = 1'b0;
   endtask

   task automatic model_reset();
      m_ext = 1'b0; m_brk = 1'b0; m_ovf = 1'b0; mkey = '0;
   endtask

   // mode 0 plain, 1 pulse ev_ready on the push edge of the stop bit, 2 check stop->valid latency.
   // Push edge = 2 sync flops + FL filter samples + emit/decode/write = FL+5 edges after the drive.
   task automatic send_bits(input logic [10:0] fr, input int n, input int mode);
      for (int i = 0; i < n; i++) begin
         ps2_dat = fr[i];
         cyc(H/2);
         ps2_clk = 1'b0;
         if (i == 10 && mode == 1) begin
            cyc(FL + 4); ev_ready = 1'b1; cyc(1); ev_ready = 1'b0; cyc(H - FL - 5);
         end else if (i == 10 && mode == 2) begin
            cyc(FL + 4); chk("latency_pre", ev_valid, 0);
            cyc(1);      chk("latency_post", ev_valid, 1);
            cyc(H - FL - 5);
         end else begin
            cyc(H);
         end
         ps2_clk = 1'b1;
         cyc(H/2);
      end
      ps2_dat = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bad, input int mode, input bit pop_same);
      logic par;
      par = bad ? ^b : ~^b;
      if (bad) model_ferr();
      else     model_byte(b, pop_same);
      send_bits({1'b1, par, b, 1'b0}, 11, mode);
      cyc(H);
   endtask

   task automatic drain();
      ev_ready = 1'b1;
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) cyc(1);
      cyc(2);
      chk("drain_empty", exp_q.size(), 0);
      chk("drain_valid", ev_valid, 0);
   endtask

   always @(negedge clk) begin
      if (frame_err) ferr_seen++;
      if (!reset && ev_valid && ev_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_event: got %0h expected none", {ev_code, ev_ext, ev_break});
         end else begin
            chk("event", {ev_code, ev_ext, ev_break}, exp_q.pop_front());
         end
      end
   end

   always @(posedge clk) if (rand_rdy) begin
      #1 ev_ready = 1'($urandom_range(0, 1));
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] b;
      cyc(5);
      chk("rst_key_down", key_down, 0);
      chk("rst_ev_valid", ev_valid, 0);
      chk("rst_ev_count", ev_count, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_frame_err", frame_err, 0);
      reset = 1'b0;
      cyc(5);

      // make / break of the space bar
      ev_ready = 1'b1;
      send_byte(8'h29, 0, 0, 0); chk("space_make", key_down, mkey);
      send_byte(8'hF0, 0, 0, 0);
      send_byte(8'h29, 0, 0, 0); chk("space_break", key_down, mkey);

      // extended key, then the same code without E0
      send_byte(8'hE0, 0, 0, 0); send_byte(8'h6B, 0, 0, 0); chk("ext_make", key_down, mkey);
      send_byte(8'hE0, 0, 0, 0); send_byte(8'hF0, 0, 0, 0);
      send_byte(8'h6B, 0, 0, 0); chk("ext_break", key_down, mkey);
      send_byte(8'h6B, 0, 0, 0); chk("plain_6b", key_down, mkey);

      // bad parity after a pending E0 clears the prefix
      send_byte(8'hE0, 0, 0, 0);
      send_byte(8'h1C, 1, 0, 0); chk("parity_err", ferr_seen, ferr_exp);
      send_byte(8'h1C, 0, 0, 0);
      drain();

      ev_ready = 1'b0;
      send_byte(8'h74, 0, 2, 0);
      drain();

      // overflow with consumer stalled
      ev_ready = 1'b0;
      for (int i = 0; i < FD + 2; i++) send_byte(8'h10 + 8'(i), 0, 0, 0);
      chk("ovf_count", ev_count, FD);
      chk("ovf_flag", overflow, m_ovf);
      chk("ovf_head", ev_code, 8'h10);
      drain();
      chk("ovf_sticky", overflow, 1);
      reset = 1'b1; cyc(3); model_reset();
      chk("ovf_cleared", overflow, 0);
      reset = 1'b0; cyc(3);

      // full FIFO with a simultaneous pop on the push edge; pointers wrap
      ev_ready = 1'b0;
      for (int i = 0; i < FD; i++) send_byte(8'h30 + 8'(i), 0, 0, 0);
      chk("full_count", ev_count, FD);
      send_byte(8'h45, 0, 1, 1);
      chk("full_push_pop_count", ev_count, FD);
      chk("full_push_pop_ovf", overflow, 0);
      drain();

      // timeout after 4 data bits, then a clean frame proves the FSM is idle
      ev_ready = 1'b1;
      send_bits({1'b1, 1'b0, 8'h33, 1'b0}, 5, 0);
      model_ferr();
      cyc(TO + 50);
      chk("timeout_err", ferr_seen, ferr_exp);
      send_byte(8'h72, 0, 0, 0);
      drain();

      // reset mid-frame abandons it
      send_bits({1'b1, ~^8'h29, 8'h29, 1'b0}, 5, 0);
      reset = 1'b1; cyc(3); model_reset(); reset = 1'b0;
      cyc(TO + 50);
      chk("midreset_no_err", ferr_seen, ferr_exp);
      chk("midreset_no_event", ev_valid, 0);
      chk("midreset_keys", key_down, mkey);

      // random byte stream with random backpressure
      rand_rdy = 1'b1;
      for (int n = 0; n < 50; n++) begin
         case ($urandom_range(0, 9))
            0: b = 8'h29;  1: b = 8'h6B;  2: b = 8'h74;  3: b = 8'h72;
            4, 5: b = 8'hE0;  6: b = 8'hF0;
            7: begin
               case ($urandom_range(0, 4))
                  0: b = 8'hE1; 1: b = 8'hAA; 2: b = 8'hFA; 3: b = 8'hEE; default: b = 8'hFE;
               endcase
            end
            default: b = 8'($urandom);
         endcase
         send_byte(b, ($urandom_range(0, 9) == 0), 0, 0);
         chk("rand_keys", key_down, mkey);
      end
      rand_rdy = 1'b0;
      cyc(2);
      drain();
      chk("rand_frame_errs", ferr_seen, ferr_exp);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
